// File: rtl/instr_encoder_loader_pkg.sv
// RV32I encoding constants, mnemonic and FSM types, and field-packing helpers
// shared by the encoder/loader and its bench.
package rv32i_enc_pkg;

  typedef enum logic [5:0] {
    MN_NOP = 6'd0,
    MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU, MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND,
    MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI, MN_SLLI, MN_SRLI, MN_SRAI,
    MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU,
    MN_SB, MN_SH, MN_SW,
    MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
    MN_JAL, MN_JALR, MN_LUI, MN_AUIPC
  } mnem_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_NORM = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [6:0] op);
    return {imm12, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm12, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OP_STORE};
  endfunction

  // b holds imm[12:1]; imm[0] of a branch offset is always zero
  function automatic logic [31:0] enc_b(input logic [11:0] b, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm20, rd, op};
  endfunction

  // j holds imm[20:1]
  function automatic logic [31:0] enc_j(input logic [19:0] j, input logic [4:0] rd);
    return {j[19], j[9:0], j[10], j[18:11], rd, OP_JAL};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bundle between a program source and the loader.
// slave is the loader side, master the side that issues requests and acks writes.
interface instr_encoder_loader_if #(parameter int ADDR_W = 9);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_mnem;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              err_illegal;
  logic              err_wrap;
  logic [ADDR_W-2:0] word_count;

  modport slave (
    input  start, in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ack,
    output in_ready, mem_wr_en, mem_addr, mem_wdata, done, err_illegal, err_wrap, word_count
  );

  modport master (
    output start, in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ack,
    input  in_ready, mem_wr_en, mem_addr, mem_wdata, done, err_illegal, err_wrap, word_count
  );
endinterface

// File: rtl/instr_encoder_loader_fifo.sv
// First-word-fall-through synchronous FIFO; pop_dat is valid whenever !empty.
// A push while full is taken only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I mnemonic requests, buffers them, and writes them to consecutive word
// addresses; first write 2 cycles after accept, in_ready falls when the buffer fills.
module instr_encoder_loader
  import rv32i_enc_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_encoder_loader_if.slave  bus
);
  localparam int                CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

  state_e              state_q, state_d;
  logic [31:0]         enc_word;
  logic                enc_legal;
  logic [4:0]          rd, rs1, rs2;
  logic [31:0]         imm;
  logic                accept, push, pop;
  logic [32:0]         fifo_rdat;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-2:0]   count_q, count_d;
  logic                wrap_q, wrap_d;
  logic                illegal_q;
  logic                unused_bits;

  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;
  assign unused_bits = ^{imm[31:21], fifo_count};

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (mnem_e'(bus.in_mnem))
      MN_NOP:   enc_word = '0;
      MN_ADD:   enc_word = enc_r(F7_NORM, F3_ADD,  rd, rs1, rs2);
      MN_SUB:   enc_word = enc_r(F7_ALT,  F3_ADD,  rd, rs1, rs2);
      MN_SLL:   enc_word = enc_r(F7_NORM, F3_SLL,  rd, rs1, rs2);
      MN_SLT:   enc_word = enc_r(F7_NORM, F3_SLT,  rd, rs1, rs2);
      MN_SLTU:  enc_word = enc_r(F7_NORM, F3_SLTU, rd, rs1, rs2);
      MN_XOR:   enc_word = enc_r(F7_NORM, F3_XOR,  rd, rs1, rs2);
      MN_SRL:   enc_word = enc_r(F7_NORM, F3_SR,   rd, rs1, rs2);
      MN_SRA:   enc_word = enc_r(F7_ALT,  F3_SR,   rd, rs1, rs2);
      MN_OR:    enc_word = enc_r(F7_NORM, F3_OR,   rd, rs1, rs2);
      MN_AND:   enc_word = enc_r(F7_NORM, F3_AND,  rd, rs1, rs2);
      MN_ADDI:  enc_word = enc_i(imm[11:0], F3_ADD,  rd, rs1, OP_IMM);
      MN_SLTI:  enc_word = enc_i(imm[11:0], F3_SLT,  rd, rs1, OP_IMM);
      MN_SLTIU: enc_word = enc_i(imm[11:0], F3_SLTU, rd, rs1, OP_IMM);
      MN_XORI:  enc_word = enc_i(imm[11:0], F3_XOR,  rd, rs1, OP_IMM);
      MN_ORI:   enc_word = enc_i(imm[11:0], F3_OR,   rd, rs1, OP_IMM);
      MN_ANDI:  enc_word = enc_i(imm[11:0], F3_AND,  rd, rs1, OP_IMM);
      // shift immediates carry funct7 in the upper bits of the I-type field
      MN_SLLI:  enc_word = enc_i({F7_NORM, imm[4:0]}, F3_SLL, rd, rs1, OP_IMM);
      MN_SRLI:  enc_word = enc_i({F7_NORM, imm[4:0]}, F3_SR,  rd, rs1, OP_IMM);
      MN_SRAI:  enc_word = enc_i({F7_ALT,  imm[4:0]}, F3_SR,  rd, rs1, OP_IMM);
      MN_LB:    enc_word = enc_i(imm[11:0], F3_B,  rd, rs1, OP_LOAD);
      MN_LH:    enc_word = enc_i(imm[11:0], F3_H,  rd, rs1, OP_LOAD);
      MN_LW:    enc_word = enc_i(imm[11:0], F3_W,  rd, rs1, OP_LOAD);
      MN_LBU:   enc_word = enc_i(imm[11:0], F3_BU, rd, rs1, OP_LOAD);
      MN_LHU:   enc_word = enc_i(imm[11:0], F3_HU, rd, rs1, OP_LOAD);
      MN_SB:    enc_word = enc_s(imm[11:0], F3_B, rs1, rs2);
      MN_SH:    enc_word = enc_s(imm[11:0], F3_H, rs1, rs2);
      MN_SW:    enc_word = enc_s(imm[11:0], F3_W, rs1, rs2);
      MN_BEQ:   enc_word = enc_b(imm[12:1], F3_BEQ,  rs1, rs2);
      MN_BNE:   enc_word = enc_b(imm[12:1], F3_BNE,  rs1, rs2);
      MN_BLT:   enc_word = enc_b(imm[12:1], F3_BLT,  rs1, rs2);
      MN_BGE:   enc_word = enc_b(imm[12:1], F3_BGE,  rs1, rs2);
      MN_BLTU:  enc_word = enc_b(imm[12:1], F3_BLTU, rs1, rs2);
      MN_BGEU:  enc_word = enc_b(imm[12:1], F3_BGEU, rs1, rs2);
      MN_JAL:   enc_word = enc_j(imm[20:1], rd);
      MN_JALR:  enc_word = enc_i(imm[11:0], 3'b000, rd, rs1, OP_JALR);
      MN_LUI:   enc_word = enc_u(imm[19:0], rd, OP_LUI);
      MN_AUIPC: enc_word = enc_u(imm[19:0], rd, OP_AUIPC);
      default:  enc_legal = 1'b0;
    endcase
  end

  assign bus.in_ready = !fifo_full && (state_q != ST_DONE) && !bus.start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && enc_legal;

  sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (bus.start),
    .push     (push),
    .push_dat ({enc_word, bus.in_last}),
    .pop      (pop),
    .pop_dat  (fifo_rdat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    wdata_d = wdata_q;
    last_d  = last_q;
    addr_d  = addr_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    if (bus.start) begin
      state_d = ST_IDLE;
      addr_d  = BASE;
      count_d = '0;
      wrap_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop               = 1'b1;
            {wdata_d, last_d} = fifo_rdat;
            state_d           = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack) begin
            addr_d  = addr_q + STEP;
            count_d = count_q + (ADDR_W-1)'(1);
            if (&addr_q[ADDR_W-1:2]) wrap_d = 1'b1;
            if (last_q) begin
              state_d = ST_DONE;
            end else if (!fifo_empty) begin
              pop               = 1'b1;
              {wdata_d, last_d} = fifo_rdat;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      addr_q    <= BASE;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      illegal_q <= accept && !enc_legal;
    end
  end

  assign bus.mem_wr_en   = (state_q == ST_WRITE);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err_illegal = illegal_q;
  assign bus.err_wrap    = wrap_q;
  assign bus.word_count  = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a 9-bit-address loader plus a 4-bit-address copy sharing the same
// request and ack stimulus, the small one used to observe address wrap.
module tb_instr_encoder_loader;
  import rv32i_enc_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [8:0]  qa[$];
  logic [31:0] qd[$];
  int          qc[$];
  logic [3:0]  qwa[$];

  instr_encoder_loader_if #(.ADDR_W(9)) ifm ();
  instr_encoder_loader_if #(.ADDR_W(4)) ifw ();

  instr_encoder_loader #(.ADDR_W(9), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut (
    .clk (clk), .reset_n (reset_n), .bus (ifm)
  );
  instr_encoder_loader #(.ADDR_W(4), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_w (
    .clk (clk), .reset_n (reset_n), .bus (ifw)
  );

  assign ifw.start    = ifm.start;
  assign ifw.in_valid = ifm.in_valid;
  assign ifw.in_mnem  = ifm.in_mnem;
  assign ifw.in_rd    = ifm.in_rd;
  assign ifw.in_rs1   = ifm.in_rs1;
  assign ifw.in_rs2   = ifm.in_rs2;
  assign ifw.in_imm   = ifm.in_imm;
  assign ifw.in_last  = ifm.in_last;
  assign ifw.mem_ack  = ifm.mem_ack;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A write completes on the next rising edge whenever wr_en && ack hold at mid-cycle
  always @(negedge clk) begin
    if (reset_n && ifm.mem_wr_en && ifm.mem_ack) begin
      qa.push_back(ifm.mem_addr);
      qd.push_back(ifm.mem_wdata);
      qc.push_back(cyc);
    end
    if (reset_n && ifw.mem_wr_en && ifw.mem_ack) qwa.push_back(ifw.mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] mn, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      output int acc);
    logic ok;
    ok  = 1'b0;
    acc = -1;
    ifm.in_valid = 1'b1;
    ifm.in_mnem  = mn;
    ifm.in_rd    = rd;
    ifm.in_rs1   = rs1;
    ifm.in_rs2   = rs2;
    ifm.in_imm   = imm;
    ifm.in_last  = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = ifm.in_ready;
      @(posedge clk);
      #1;
    end
    acc = cyc;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_start();
    ifm.start = 1'b1;
    @(negedge clk);
    chk("start_in_ready_low", {31'd0, ifm.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    ifm.start = 1'b0;
  endtask

  task automatic clear_q();
    qa.delete();
    qd.delete();
    qc.delete();
    qwa.delete();
  endtask

  initial begin
    int a0, a1, a2;
    int unstable;
    logic seen;
    logic [8:0] cap_a;
    logic [31:0] cap_d;
    logic [8:0]  exp_a3 [6];
    logic [31:0] exp_d3 [6];

    reset_n      = 1'b0;
    ifm.start    = 1'b0;
    ifm.in_valid = 1'b0;
    ifm.in_mnem  = '0;
    ifm.in_rd    = '0;
    ifm.in_rs1   = '0;
    ifm.in_rs2   = '0;
    ifm.in_imm   = '0;
    ifm.in_last  = 1'b0;
    ifm.mem_ack  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", {31'd0, ifm.mem_wr_en}, 32'd0);
    chk("rst_addr", {23'd0, ifm.mem_addr}, 32'd0);
    chk("rst_wdata", ifm.mem_wdata, 32'd0);
    chk("rst_done", {31'd0, ifm.done}, 32'd0);
    chk("rst_err_illegal", {31'd0, ifm.err_illegal}, 32'd0);
    chk("rst_err_wrap", {31'd0, ifm.err_wrap}, 32'd0);
    chk("rst_word_count", {24'd0, ifm.word_count}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, ifm.in_ready}, 32'd1);

    // ALU ops streaming with ack tied high
    tick(1);
    ifm.mem_ack = 1'b1;
    clear_q();
    send(MN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, a0);
    send(MN_ADD,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a1);
    send(MN_SUB,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a1);
    ifm.in_valid = 1'b0;
    tick(6);
    chk("t1_count", qd.size(), 32'd3);
    chk("t1_d0", qd[0], 32'h00500093);
    chk("t1_d1", qd[1], 32'h002081B3);
    chk("t1_d2", qd[2], 32'h402081B3);
    chk("t1_a0", {23'd0, qa[0]}, 32'd0);
    chk("t1_a1", {23'd0, qa[1]}, 32'd4);
    chk("t1_a2", {23'd0, qa[2]}, 32'd8);
    chk("t1_latency", qc[0], a0 + 1);
    chk("t1_b2b_1", qc[1], a0 + 2);
    chk("t1_b2b_2", qc[2], a0 + 3);
    chk("t1_word_count", {24'd0, ifm.word_count}, 32'd3);
    chk("t1_done", {31'd0, ifm.done}, 32'd0);

    // S/J/I-shift/U types ending in last
    pulse_start();
    clear_q();
    send(MN_SW,   5'd0, 5'd1, 5'd2, 32'd8,       1'b0, a0);
    send(MN_JAL,  5'd1, 5'd0, 5'd0, 32'd8,       1'b0, a0);
    send(MN_SRAI, 5'd5, 5'd6, 5'd0, 32'd3,       1'b0, a0);
    send(MN_LUI,  5'd5, 5'd0, 5'd0, 32'h12345,   1'b1, a0);
    ifm.in_valid = 1'b0;
    tick(6);
    chk("t2_count", qd.size(), 32'd4);
    chk("t2_sw", qd[0], 32'h0020A423);
    chk("t2_jal", qd[1], 32'h008000EF);
    chk("t2_srai", qd[2], 32'h40335293);
    chk("t2_lui", qd[3], 32'h123452B7);
    chk("t2_a3", {23'd0, qa[3]}, 32'd12);
    chk("t2_done", {31'd0, ifm.done}, 32'd1);
    chk("t2_word_count", {24'd0, ifm.word_count}, 32'd4);
    chk("t2_ready_in_done", {31'd0, ifm.in_ready}, 32'd0);

    // Stalled memory: 6 requests offered while ack is low for 10 cycles
    pulse_start();
    clear_q();
    ifm.mem_ack = 1'b0;
    exp_d3[0] = 32'h00100093; exp_d3[1] = 32'hFE208EE3; exp_d3[2] = 32'hFF832283;
    exp_d3[3] = 32'hFFFFF397; exp_d3[4] = 32'h000280E7; exp_d3[5] = 32'h00000000;
    for (int i = 0; i < 6; i++) exp_a3[i] = 9'(4 * i);
    unstable = 0;
    seen     = 1'b0;
    cap_a    = '0;
    cap_d    = '0;
    fork
      begin
        send(MN_ADDI,  5'd1, 5'd0, 5'd0, 32'd1,        1'b0, a2);
        send(MN_BEQ,   5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, a2);
        send(MN_LW,    5'd5, 5'd6, 5'd0, 32'hFFFFFFF8, 1'b0, a2);
        send(MN_AUIPC, 5'd7, 5'd0, 5'd0, 32'h000FFFFF, 1'b0, a2);
        send(MN_JALR,  5'd1, 5'd5, 5'd0, 32'd0,        1'b0, a2);
        send(MN_NOP,   5'd3, 5'd4, 5'd5, 32'h123,      1'b1, a2);
        ifm.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (ifm.mem_wr_en) begin
            if (!seen) begin
              seen  = 1'b1;
              cap_a = ifm.mem_addr;
              cap_d = ifm.mem_wdata;
            end else if (ifm.mem_addr !== cap_a || ifm.mem_wdata !== cap_d) begin
              unstable++;
            end
          end
        end
        chk("t3_stall_stable", unstable, 32'd0);
        chk("t3_stall_wr_en", {31'd0, ifm.mem_wr_en}, 32'd1);
        chk("t3_stall_addr", {23'd0, ifm.mem_addr}, 32'd0);
        chk("t3_stall_data", ifm.mem_wdata, 32'h00100093);
        chk("t3_stall_ready", {31'd0, ifm.in_ready}, 32'd0);
        chk("t3_stall_no_write", qd.size(), 32'd0);
        @(posedge clk);
        #1;
        ifm.mem_ack = 1'b1;
      end
    join
    tick(10);
    chk("t3_count", qd.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_d%0d", i), qd[i], exp_d3[i]);
      chk($sformatf("t3_a%0d", i), {23'd0, qa[i]}, {23'd0, exp_a3[i]});
    end
    chk("t3_done", {31'd0, ifm.done}, 32'd1);
    chk("t3_word_count", {24'd0, ifm.word_count}, 32'd6);

    // Unknown mnemonic marked last: pulse only, nothing written, not done
    pulse_start();
    clear_q();
    send(6'h3F, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, a0);
    ifm.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_illegal_pulse", {31'd0, ifm.err_illegal}, 32'd1);
    @(negedge clk);
    chk("t4_illegal_clear", {31'd0, ifm.err_illegal}, 32'd0);
    tick(5);
    chk("t4_no_write", qd.size(), 32'd0);
    chk("t4_done", {31'd0, ifm.done}, 32'd0);
    chk("t4_word_count", {24'd0, ifm.word_count}, 32'd0);
    chk("t4_ready", {31'd0, ifm.in_ready}, 32'd1);

    // Five words into a 16-byte space: the fifth lands at 0 and flags wrap
    pulse_start();
    clear_q();
    send(MN_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, a0);
    send(MN_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, a0);
    send(MN_ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, a0);
    send(MN_ADDI, 5'd4, 5'd0, 5'd0, 32'd4, 1'b0, a0);
    send(MN_ADDI, 5'd5, 5'd0, 5'd0, 32'd5, 1'b1, a0);
    ifm.in_valid = 1'b0;
    tick(6);
    chk("t5_w_count", qwa.size(), 32'd5);
    chk("t5_w_a3", {28'd0, qwa[3]}, 32'd12);
    chk("t5_w_a4", {28'd0, qwa[4]}, 32'd0);
    chk("t5_w_err_wrap", {31'd0, ifw.err_wrap}, 32'd1);
    chk("t5_w_word_count", {29'd0, ifw.word_count}, 32'd5);
    chk("t5_w_addr_after", {28'd0, ifw.mem_addr}, 32'd4);
    chk("t5_m_err_wrap", {31'd0, ifm.err_wrap}, 32'd0);
    chk("t5_m_addr_after", {23'd0, ifm.mem_addr}, 32'd20);
    chk("t5_m_d4", qd[4], 32'h00500293);
    pulse_start();
    @(negedge clk);
    chk("t5_w_wrap_cleared", {31'd0, ifw.err_wrap}, 32'd0);
    chk("t5_w_count_cleared", {29'd0, ifw.word_count}, 32'd0);
    chk("t5_w_done_cleared", {31'd0, ifw.done}, 32'd0);

    // start abandons an in-flight write and flushes two buffered words
    tick(1);
    clear_q();
    ifm.mem_ack = 1'b0;
    send(MN_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, a0);
    send(MN_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, a0);
    send(MN_ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, a0);
    ifm.in_valid = 1'b0;
    tick(2);
    @(negedge clk);
    chk("t6_wr_en_before", {31'd0, ifm.mem_wr_en}, 32'd1);
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    chk("t6_wr_en_dropped", {31'd0, ifm.mem_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    ifm.mem_ack = 1'b1;
    tick(5);
    chk("t6_flushed", qd.size(), 32'd0);
    chk("t6_word_count", {24'd0, ifm.word_count}, 32'd0);
    send(MN_LUI, 5'd5, 5'd0, 5'd0, 32'h12345, 1'b1, a0);
    ifm.in_valid = 1'b0;
    tick(5);
    chk("t6_new_count", qd.size(), 32'd1);
    chk("t6_new_addr", {23'd0, qa[0]}, 32'd0);
    chk("t6_new_data", qd[0], 32'h123452B7);
    chk("t6_done", {31'd0, ifm.done}, 32'd1);

    // Asynchronous reset in the middle of a stalled write
    pulse_start();
    ifm.mem_ack = 1'b0;
    send(MN_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a0);
    ifm.in_valid = 1'b0;
    tick(3);
    @(negedge clk);
    chk("t7_wr_en_before", {31'd0, ifm.mem_wr_en}, 32'd1);
    chk("t7_wdata_before", ifm.mem_wdata, 32'h002081B3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_wr_en", {31'd0, ifm.mem_wr_en}, 32'd0);
    chk("t7_rst_wdata", ifm.mem_wdata, 32'd0);
    chk("t7_rst_addr", {23'd0, ifm.mem_addr}, 32'd0);
    chk("t7_rst_done", {31'd0, ifm.done}, 32'd0);
    chk("t7_rst_word_count", {24'd0, ifm.word_count}, 32'd0);
    chk("t7_rst_err_wrap", {31'd0, ifm.err_wrap}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
